jtframe_ram_req: RTL and testbench

JTFRAME_RAM_REQ -- requirements
Module: jtframe_ram_req

---
 rtl/jtframe_ram_req_pkg.sv | 18 +
 rtl/jtframe_rq_dout.sv | 66 ++++++
 rtl/jtframe_ram_req.sv | 136 +++++++++++++
 tb/tb_jtframe_ram_req.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_ram_req_pkg.sv
// Shared types for the SDRAM client request block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package jtframe_ram_req_pkg;

    // Life cycle of one client access:
    //   ST_IDLE  - nothing outstanding (data_ok may still be held for the client)
    //   ST_REQ   - req raised, waiting for the arbiter grant (we)
    //   ST_WAIT  - granted, client still selected, waiting for din_ok
    //   ST_DRAIN - granted but the client dropped addr_ok; let SDRAM finish silently
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } rq_state_t;

endpackage

// File: rtl/jtframe_rq_dout.sv
// Read data capture and width-dependent output mux for jtframe_ram_req.
// Latency: captures on the dst/din_ok edge, dout valid right after that edge.
// Backpressure: none; capture enables are qualified by the parent.
//   i_clk/i_rst   : clock, synchronous active-high reset
//   i_start       : access start pulse, samples the byte select
//   i_bsel        : client addr[0] (byte lane for DW=8)
//   i_cap_lo/hi   : load i_din into the low / high 16-bit half
//   i_din         : SDRAM read word
//   o_dout        : read data to the client
module jtframe_rq_dout #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_bsel,
    input  logic          i_cap_lo,
    input  logic          i_cap_hi,
    input  logic [15:0]   i_din,
    output logic [DW-1:0] o_dout
);

    localparam int DW_BYTE = 8;
    localparam int DW_WORD = 16;

    logic [15:0] r_lo;

    always_ff @(posedge i_clk) begin
        if (i_rst)         r_lo <= 16'h0000;
        else if (i_cap_lo) r_lo <= i_din;
    end

    generate
        if (DW == DW_BYTE) begin : g_byte
            // Byte lane is frozen at start so address changes while the
            // client holds addr_ok cannot flip the returned byte.
            logic r_bsel;
            logic w_unused_hi;

            always_ff @(posedge i_clk) begin
                if (i_rst)        r_bsel <= 1'b0;
                else if (i_start) r_bsel <= i_bsel;
            end

            assign o_dout      = r_bsel ? r_lo[15:8] : r_lo[7:0];
            assign w_unused_hi = i_cap_hi;
        end else if (DW == DW_WORD) begin : g_word
            logic w_unused_ctl;

            assign o_dout       = r_lo;
            assign w_unused_ctl = i_start ^ i_bsel ^ i_cap_hi;
        end else begin : g_dword
            logic [15:0] r_hi;
            logic        w_unused_ctl;

            always_ff @(posedge i_clk) begin
                if (i_rst)         r_hi <= 16'h0000;
                else if (i_cap_hi) r_hi <= i_din;
            end

            assign o_dout       = {r_hi, r_lo};
            assign w_unused_ctl = i_start ^ i_bsel;
        end
    endgenerate

endmodule

// File: rtl/jtframe_ram_req.sv
// Client-side SDRAM request block: turns an addr_ok rising edge into one arbiter access.
// Latency: req one edge after start; read data_ok on the we & din_ok edge (fast writes: with req).
// Backpressure: req is held until the arbiter grants (we); dropping addr_ok cancels or orphans it.
//   clk/rst            : clock, synchronous active-high reset
//   addr/addr_ok       : client address and chip select (rising edge = new access)
//   offset             : SDRAM word base added to the client word address
//   wrdata/wrin        : write data (routed to the arbiter elsewhere) and write flag
//   req/req_rnw        : request and direction toward the arbiter
//   sdram_addr         : SDRAM word address (combinational)
//   din/din_ok/dst/we  : SDRAM data, completion, first-word strobe, slot grant
//   dout/data_ok       : read data and completion toward the client
module jtframe_ram_req
    import jtframe_ram_req_pkg::*;
#(
    parameter int SDRAMW = 22,
    parameter int AW     = 18,
    parameter int DW     = 8,
    parameter int FASTWR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     addr,
    input  logic              addr_ok,
    input  logic [SDRAMW-1:0] offset,
    input  logic [DW-1:0]     wrdata,
    input  logic              wrin,
    output logic              req_rnw,
    output logic [SDRAMW-1:0] sdram_addr,
    input  logic [15:0]       din,
    input  logic              din_ok,
    input  logic              dst,
    output logic [DW-1:0]     dout,
    output logic              req,
    output logic              data_ok,
    input  logic              we
);

    localparam int DW_BYTE = 8;

    rq_state_t   r_state;
    rq_state_t   w_next;
    logic        r_last_cs;
    logic        r_rnw;
    logic        r_data_ok;
    logic        w_start;
    logic        w_live;
    logic        w_done;
    logic        w_unused_wrdata;
    logic [SDRAMW-1:0] w_word_addr;

    // Byte-addressed clients drop addr[0]; it only selects the byte lane.
    generate
        if (DW == DW_BYTE) begin : g_waddr_byte
            assign w_word_addr = SDRAMW'(addr[AW-1:1]);
        end else begin : g_waddr_word
            assign w_word_addr = SDRAMW'(addr);
        end
    endgenerate

    assign sdram_addr      = offset + w_word_addr;
    assign w_start         = addr_ok & ~r_last_cs;
    assign req_rnw         = r_rnw;
    assign data_ok         = r_data_ok;
    assign w_unused_wrdata = ^wrdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state: a fresh start always wins, even over a completion
    // landing on the same edge.
    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = ST_REQ;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (we)            w_next = din_ok ? ST_IDLE : (addr_ok ? ST_WAIT : ST_DRAIN);
                    else if (!addr_ok) w_next = ST_IDLE;
                end
                ST_WAIT: begin
                    if (we && din_ok)  w_next = ST_IDLE;
                    else if (!addr_ok) w_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (we && din_ok)  w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs: only a granted access whose client is still selected may
    // deliver data; orphaned (drained) completions are dropped.
    always_comb begin
        req    = (r_state == ST_REQ);
        w_live = ((r_state == ST_REQ) || (r_state == ST_WAIT)) && addr_ok;
        w_done = w_live && we && din_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_cs <= 1'b0;
            r_rnw     <= 1'b1;
            r_data_ok <= 1'b0;
        end else begin
            r_last_cs <= addr_ok;
            if (w_start) begin
                r_rnw     <= ~wrin;
                // Fast writes are acknowledged as soon as they are posted.
                r_data_ok <= (FASTWR != 0) && wrin;
            end else if (!addr_ok) begin
                r_data_ok <= 1'b0;
            end else if (w_done) begin
                r_data_ok <= 1'b1;
            end
        end
    end

    jtframe_rq_dout #(
        .DW (DW)
    ) u_dout (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (w_start),
        .i_bsel   (addr[0]),
        .i_cap_lo (w_live && we && dst && r_rnw),
        .i_cap_hi (w_done && r_rnw),
        .i_din    (din),
        .o_dout   (dout)
    );

endmodule

// File: tb/tb_jtframe_ram_req.sv
module tb_jtframe_ram_req;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        addr_ok;
    logic [21:0] offset;
    logic [31:0] wrdata;
    logic        wrin;
    logic [15:0] din;
    logic        din_ok;
    logic        dst;
    logic        we;

    // a: DW=16, b: DW=8, c: DW=32, d: DW=16 with fast writes
    logic        req_a, rnw_a, dok_a;
    logic        req_b, rnw_b, dok_b;
    logic        req_c, rnw_c, dok_c;
    logic        req_d, rnw_d, dok_d;
    logic [21:0] sa_a, sa_b, sa_c, sa_d;
    logic [15:0] dout_a, dout_d;
    logic [7:0]  dout_b;
    logic [31:0] dout_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtframe_ram_req #(.SDRAMW(22), .AW(18), .DW(16), .FASTWR(0)) u_a (
        .clk(clk), .rst(rst), .addr(addr), .addr_ok(addr_ok), .offset(offset),
        .wrdata(wrdata[15:0]), .wrin(wrin), .req_rnw(rnw_a), .sdram_addr(sa_a),
        .din(din), .din_ok(din_ok), .dst(dst), .dout(dout_a), .req(req_a),
        .data_ok(dok_a), .we(we));

    jtframe_ram_req #(.SDRAMW(22), .AW(18), .DW(8), .FASTWR(0)) u_b (
        .clk(clk), .rst(rst), .addr(addr), .addr_ok(addr_ok), .offset(offset),
        .wrdata(wrdata[7:0]), .wrin(wrin), .req_rnw(rnw_b), .sdram_addr(sa_b),
        .din(din), .din_ok(din_ok), .dst(dst), .dout(dout_b), .req(req_b),
        .data_ok(dok_b), .we(we));

    jtframe_ram_req #(.SDRAMW(22), .AW(18), .DW(32), .FASTWR(0)) u_c (
        .clk(clk), .rst(rst), .addr(addr), .addr_ok(addr_ok), .offset(offset),
        .wrdata(wrdata), .wrin(wrin), .req_rnw(rnw_c), .sdram_addr(sa_c),
        .din(din), .din_ok(din_ok), .dst(dst), .dout(dout_c), .req(req_c),
        .data_ok(dok_c), .we(we));

    jtframe_ram_req #(.SDRAMW(22), .AW(18), .DW(16), .FASTWR(1)) u_d (
        .clk(clk), .rst(rst), .addr(addr), .addr_ok(addr_ok), .offset(offset),
        .wrdata(wrdata[15:0]), .wrin(wrin), .req_rnw(rnw_d), .sdram_addr(sa_d),
        .din(din), .din_ok(din_ok), .dst(dst), .dout(dout_d), .req(req_d),
        .data_ok(dok_d), .we(we));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Standard single-word read handshake; leaves addr_ok high.
    task automatic run_read(input logic [17:0] a, input logic [15:0] d);
        addr = a; addr_ok = 1'b1; wrin = 1'b0;
        tick();
        we = 1'b1;
        tick();
        dst = 1'b1; din_ok = 1'b1; din = d;
        tick();
        we = 1'b0; dst = 1'b0; din_ok = 1'b0;
    endtask

    task automatic release_cs();
        addr_ok = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = '0; addr_ok = 1'b0; offset = '0; wrdata = 32'hCAFE_F00D;
        wrin = 1'b0; din = '0; din_ok = 1'b0; dst = 1'b0; we = 1'b0;
        tick(); tick();
        checks++; if (req_a !== 1'b0)   begin errors++; $display("FAIL rst_req: got %b want 0", req_a); end
        checks++; if (rnw_a !== 1'b1)   begin errors++; $display("FAIL rst_rnw: got %b want 1", rnw_a); end
        checks++; if (dok_a !== 1'b0)   begin errors++; $display("FAIL rst_dok: got %b want 0", dok_a); end
        checks++; if (dout_a !== 16'h0) begin errors++; $display("FAIL rst_dout16: got %h want 0", dout_a); end
        checks++; if (dout_b !== 8'h0)  begin errors++; $display("FAIL rst_dout8: got %h want 0", dout_b); end
        checks++; if (dout_c !== 32'h0) begin errors++; $display("FAIL rst_dout32: got %h want 0", dout_c); end
        checks++; if (dok_d !== 1'b0)   begin errors++; $display("FAIL rst_dok_fast: got %b want 0", dok_d); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read16();
        offset = 22'h1000; addr = 18'h20; addr_ok = 1'b1;
        #1;
        checks++; if (sa_a !== 22'h1020) begin errors++; $display("FAIL rd16_addr: got %h want 1020", sa_a); end
        tick();
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL rd16_req: got %b want 1", req_a); end
        checks++; if (rnw_a !== 1'b1) begin errors++; $display("FAIL rd16_rnw: got %b want 1", rnw_a); end
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL rd16_dok_early: got %b want 0", dok_a); end
        we = 1'b1;
        tick();
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL rd16_req_grant: got %b want 0", req_a); end
        dst = 1'b1; din_ok = 1'b1; din = 16'hBEEF;
        tick();
        checks++; if (dout_a !== 16'hBEEF) begin errors++; $display("FAIL rd16_dout: got %h want beef", dout_a); end
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL rd16_dok: got %b want 1", dok_a); end
        checks++; if (dout_c !== 32'hBEEF_BEEF) begin errors++; $display("FAIL rd16_dout32: got %h want beefbeef", dout_c); end
        we = 1'b0; dst = 1'b0; din_ok = 1'b0;
        tick();
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL rd16_dok_hold: got %b want 1", dok_a); end
        release_cs();
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL rd16_dok_clear: got %b want 0", dok_a); end
    endtask

    task automatic test_read8();
        addr = 18'h41;
        #1;
        checks++; if (sa_b !== 22'h1020) begin errors++; $display("FAIL rd8_addr: got %h want 1020", sa_b); end
        checks++; if (sa_a !== 22'h1041) begin errors++; $display("FAIL rd8_addr16: got %h want 1041", sa_a); end
        run_read(18'h41, 16'h12AB);
        checks++; if (dout_b !== 8'h12) begin errors++; $display("FAIL rd8_hi: got %h want 12", dout_b); end
        checks++; if (dok_b !== 1'b1)   begin errors++; $display("FAIL rd8_dok: got %b want 1", dok_b); end
        // Byte lane must stay as sampled at start while addr_ok is held.
        addr = 18'h40;
        tick();
        checks++; if (dout_b !== 8'h12) begin errors++; $display("FAIL rd8_bsel_held: got %h want 12", dout_b); end
        release_cs();
        run_read(18'h40, 16'h12AB);
        checks++; if (dout_b !== 8'hAB) begin errors++; $display("FAIL rd8_lo: got %h want ab", dout_b); end
        release_cs();
    endtask

    task automatic test_read32();
        addr = 18'h10; addr_ok = 1'b1; wrin = 1'b0;
        tick();
        we = 1'b1;
        tick();
        dst = 1'b1; din = 16'h5678;
        tick();
        checks++; if (dok_c !== 1'b0) begin errors++; $display("FAIL rd32_dok_dst: got %b want 0", dok_c); end
        dst = 1'b0; din_ok = 1'b1; din = 16'h1234;
        tick();
        checks++; if (dout_c !== 32'h1234_5678) begin errors++; $display("FAIL rd32_dout: got %h want 12345678", dout_c); end
        checks++; if (dok_c !== 1'b1) begin errors++; $display("FAIL rd32_dok: got %b want 1", dok_c); end
        checks++; if (dout_a !== 16'h5678) begin errors++; $display("FAIL rd32_dout16: got %h want 5678", dout_a); end
        we = 1'b0; din_ok = 1'b0;
        release_cs();
    endtask

    task automatic test_write();
        addr = 18'h30; addr_ok = 1'b1; wrin = 1'b1;
        tick();
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL wr_req: got %b want 1", req_a); end
        checks++; if (rnw_a !== 1'b0) begin errors++; $display("FAIL wr_rnw: got %b want 0", rnw_a); end
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL wr_dok_early: got %b want 0", dok_a); end
        checks++; if (dok_d !== 1'b1) begin errors++; $display("FAIL wr_fast_dok: got %b want 1", dok_d); end
        checks++; if (req_d !== 1'b1) begin errors++; $display("FAIL wr_fast_req: got %b want 1", req_d); end
        wrin = 1'b0;
        tick();
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL wr_dok_wait: got %b want 0", dok_a); end
        we = 1'b1;
        tick();
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL wr_req_grant: got %b want 0", req_a); end
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL wr_dok_grant: got %b want 0", dok_a); end
        din_ok = 1'b1;
        tick();
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL wr_dok_done: got %b want 1", dok_a); end
        checks++; if (dok_d !== 1'b1) begin errors++; $display("FAIL wr_fast_dok_done: got %b want 1", dok_d); end
        we = 1'b0; din_ok = 1'b0;
        release_cs();
        checks++; if (dok_d !== 1'b0) begin errors++; $display("FAIL wr_fast_dok_clear: got %b want 0", dok_d); end
    endtask

    task automatic test_abort_before_grant();
        addr = 18'h50; addr_ok = 1'b1;
        tick();
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL abt1_req: got %b want 1", req_a); end
        addr_ok = 1'b0;
        tick();
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL abt1_req_clear: got %b want 0", req_a); end
        tick();
        // Stray SDRAM strobes with no grant are ignored.
        we = 1'b0; dst = 1'b1; din_ok = 1'b1; din = 16'h9999;
        tick();
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL abt1_dok: got %b want 0", dok_a); end
        checks++; if (dout_a !== 16'h5678) begin errors++; $display("FAIL abt1_dout: got %h want 5678", dout_a); end
        dst = 1'b0; din_ok = 1'b0;
        tick();
    endtask

    task automatic test_abort_after_grant();
        addr = 18'h60; addr_ok = 1'b1;
        tick();
        we = 1'b1;
        tick();
        addr_ok = 1'b0;
        tick();
        // Orphaned completion coincides with a new client start.
        addr = 18'h70; addr_ok = 1'b1; dst = 1'b1; din_ok = 1'b1; din = 16'hDEAD;
        tick();
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL abt2_req_new: got %b want 1", req_a); end
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL abt2_dok: got %b want 0", dok_a); end
        checks++; if (dout_a !== 16'h5678) begin errors++; $display("FAIL abt2_dout: got %h want 5678", dout_a); end
        checks++; if (dout_c !== 32'h1234_5678) begin errors++; $display("FAIL abt2_dout32: got %h want 12345678", dout_c); end
        we = 1'b0; dst = 1'b0; din_ok = 1'b0;
        tick();
        release_cs();
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL abt2_req_clear: got %b want 0", req_a); end
    endtask

    task automatic test_hold_addr();
        run_read(18'h80, 16'h1111);
        checks++; if (dout_a !== 16'h1111) begin errors++; $display("FAIL hold_dout: got %h want 1111", dout_a); end
        addr = 18'h90;
        tick();
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL hold_no_start: got %b want 0", req_a); end
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL hold_dok: got %b want 1", dok_a); end
        release_cs();
    endtask

    task automatic test_reset_mid();
        addr = 18'hA0; addr_ok = 1'b1;
        tick();
        we = 1'b1;
        tick();
        dst = 1'b1; din = 16'h2222;
        tick();
        checks++; if (dout_a !== 16'h2222) begin errors++; $display("FAIL rstm_capture: got %h want 2222", dout_a); end
        dst = 1'b0; we = 1'b0; rst = 1'b1;
        tick();
        checks++; if (req_a !== 1'b0)   begin errors++; $display("FAIL rstm_req: got %b want 0", req_a); end
        checks++; if (dok_a !== 1'b0)   begin errors++; $display("FAIL rstm_dok: got %b want 0", dok_a); end
        checks++; if (dout_a !== 16'h0) begin errors++; $display("FAIL rstm_dout: got %h want 0", dout_a); end
        checks++; if (dout_c !== 32'h0) begin errors++; $display("FAIL rstm_dout32: got %h want 0", dout_c); end
        // addr_ok still high: first cycle out of reset counts as a rising edge.
        rst = 1'b0;
        tick();
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL rstm_first_edge: got %b want 1", req_a); end
        release_cs();
    endtask

    initial begin
        test_reset();
        test_read16();
        test_read8();
        test_read32();
        test_write();
        test_abort_before_grant();
        test_abort_after_grant();
        test_hold_addr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
